mem_wb_hilo: RTL and testbench

- Pipeline register between the memory stage and write-back, with stall bubble and flush control.
- Also holds the architectural HI/LO register pair, committed from the write-back stage.
- Provides bypassed HI/LO read ports to the execute stage (MFHI/MFLO) so a pending write-back commit is visible without a stall.
- General-purpose register write-back fields (wb_dest_addr/wb_wreg/wb_dest_data) go directly to the register file write port.

---
 rtl/mem_wb_hilo.sv | 83 ++++++++
 tb/tb_mem_wb_hilo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline register with stall/flush control, plus the architectural
// HI/LO pair committed from write-back and bypassed to the execute stage.
module mem_wb_hilo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_dest_addr,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_dest_data,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              mem_whilo,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  output logic [ADDR_W-1:0] wb_dest_addr,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_dest_data,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata
);

  logic [ADDR_W-1:0] r_wb_dest_addr;
  logic              r_wb_wreg;
  logic [DATA_W-1:0] r_wb_dest_data;
  logic [DATA_W-1:0] r_wb_hi;
  logic [DATA_W-1:0] r_wb_lo;
  logic              r_wb_whilo;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              w_bubble;
  logic              w_wreg_in;

  // A flush always wins over a write-back stall; a memory stall alone
  // drains a bubble into write-back.
  assign w_bubble  = flush || (!stall_wb && stall_mem);
  // Register 0 is hard-wired; suppress only the enable so the data still flows.
  assign w_wreg_in = mem_wreg && (mem_dest_addr != '0);

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_wb_dest_addr <= '0;
      r_wb_wreg      <= 1'b0;
      r_wb_dest_data <= '0;
      r_wb_hi        <= '0;
      r_wb_lo        <= '0;
      r_wb_whilo     <= 1'b0;
    end else if (!stall_wb) begin
      r_wb_dest_addr <= mem_dest_addr;
      r_wb_wreg      <= w_wreg_in;
      r_wb_dest_data <= mem_dest_data;
      r_wb_hi        <= mem_hi;
      r_wb_lo        <= mem_lo;
      r_wb_whilo     <= mem_whilo;
    end
  end

  // The instruction already in write-back retires regardless of flush/stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_wb_whilo) begin
      r_hi <= r_wb_hi;
      r_lo <= r_wb_lo;
    end
  end

  assign wb_dest_addr = r_wb_dest_addr;
  assign wb_wreg      = r_wb_wreg;
  assign wb_dest_data = r_wb_dest_data;
  assign wb_hi        = r_wb_hi;
  assign wb_lo        = r_wb_lo;
  assign wb_whilo     = r_wb_whilo;
  assign hi_rdata     = r_wb_whilo ? r_wb_hi : r_hi;
  assign lo_rdata     = r_wb_whilo ? r_wb_lo : r_lo;

endmodule

// File: tb/tb_mem_wb_hilo.sv
// Bench for mem_wb_hilo: reference model feeds an expected queue each edge,
// scenario tasks pop and compare, plus fixed-value checks of key scenarios.
module tb_mem_wb_hilo;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int VW = 1 + ADDR_W + DATA_W + 1 + 4 * DATA_W;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] mem_dest_addr;
  logic              mem_wreg;
  logic [DATA_W-1:0] mem_dest_data;
  logic [DATA_W-1:0] mem_hi;
  logic [DATA_W-1:0] mem_lo;
  logic              mem_whilo;
  logic              stall_mem;
  logic              stall_wb;
  logic              flush;
  logic [ADDR_W-1:0] wb_dest_addr;
  logic              wb_wreg;
  logic [DATA_W-1:0] wb_dest_data;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic              wb_whilo;
  logic [DATA_W-1:0] hi_rdata;
  logic [DATA_W-1:0] lo_rdata;

  mem_wb_hilo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .mem_dest_addr(mem_dest_addr), .mem_wreg(mem_wreg), .mem_dest_data(mem_dest_data),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .wb_dest_addr(wb_dest_addr), .wb_wreg(wb_wreg), .wb_dest_data(wb_dest_data),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] got;
  logic [VW-1:0] e;
  assign got = {wb_wreg, wb_dest_addr, wb_dest_data, wb_whilo, wb_hi, wb_lo, hi_rdata, lo_rdata};

  // reference model state
  logic [ADDR_W-1:0] m_addr;
  logic              m_wreg;
  logic [DATA_W-1:0] m_data, m_hi, m_lo, m_hreg, m_lreg;
  logic              m_whilo;

  // Advance one edge: update the model from the driven inputs and queue the
  // expected output vector, then sample 1 time unit after the edge.
  task automatic tick();
    logic [DATA_W-1:0] rh, rl;
    @(posedge clk);
    if (rst) begin
      m_hreg = '0; m_lreg = '0;
    end else if (m_whilo) begin
      m_hreg = m_hi; m_lreg = m_lo;
    end
    if (rst || flush || (stall_mem && !stall_wb)) begin
      m_addr = '0; m_wreg = 1'b0; m_data = '0; m_hi = '0; m_lo = '0; m_whilo = 1'b0;
    end else if (!stall_wb) begin
      m_addr = mem_dest_addr; m_wreg = mem_wreg && (mem_dest_addr != 0);
      m_data = mem_dest_data; m_hi = mem_hi; m_lo = mem_lo; m_whilo = mem_whilo;
    end
    rh = m_whilo ? m_hi : m_hreg;
    rl = m_whilo ? m_lo : m_lreg;
    exp_q.push_back({m_wreg, m_addr, m_data, m_whilo, m_hi, m_lo, rh, rl});
    #1;
  endtask

  // driver tasks
  task automatic drive(input logic wreg, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data, input logic whilo,
                       input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo);
    @(negedge clk);
    mem_wreg = wreg; mem_dest_addr = addr; mem_dest_data = data;
    mem_whilo = whilo; mem_hi = hi; mem_lo = lo;
  endtask

  task automatic ctrl(input logic r, input logic fl, input logic sm, input logic sw);
    rst = r; flush = fl; stall_mem = sm; stall_wb = sw;
  endtask

  task automatic test_reset();
    ctrl(1, 0, 0, 0);
    drive(1, 5'd7, 32'h1111_2222, 1, 32'h3333_4444, 32'h5555_6666);
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL reset_model: got=%h exp=%h", got, e); end
      checks++;
      if ({wb_wreg, wb_whilo, wb_dest_data, hi_rdata, lo_rdata} !== '0) begin
        failures++; $display("FAIL reset_zero: wb_dest_data=%h hi_rdata=%h lo_rdata=%h", wb_dest_data, hi_rdata, lo_rdata);
      end
    end
    drive(1, 5'd5, 32'hDEAD_BEEF, 0, 32'h0, 32'h0);
    ctrl(0, 0, 0, 0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL capture_model: got=%h exp=%h", got, e); end
    checks++;
    if ({wb_wreg, wb_dest_addr, wb_dest_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL capture: wreg=%b addr=%0d data=%h exp 1/5/deadbeef", wb_wreg, wb_dest_addr, wb_dest_data);
    end
  endtask

  task automatic test_hilo_bypass();
    drive(0, 5'd0, 32'h0, 1, 32'h1234_5678, 32'h9ABC_DEF0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL hilo_cap_model: got=%h exp=%h", got, e); end
    checks++;
    if ({hi_rdata, lo_rdata} !== {32'h1234_5678, 32'h9ABC_DEF0}) begin
      failures++; $display("FAIL hilo_bypass: hi=%h lo=%h exp 12345678/9abcdef0", hi_rdata, lo_rdata);
    end
    drive(0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL hilo_commit_model: got=%h exp=%h", got, e); end
      checks++;
      if ({wb_whilo, hi_rdata, lo_rdata} !== {1'b0, 32'h1234_5678, 32'h9ABC_DEF0}) begin
        failures++; $display("FAIL hilo_commit: whilo=%b hi=%h lo=%h exp 0/12345678/9abcdef0", wb_whilo, hi_rdata, lo_rdata);
      end
    end
  endtask

  task automatic test_stall();
    drive(1, 5'd9, 32'hCAFE_0001, 0, 32'h0, 32'h0);
    ctrl(0, 0, 1, 0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL stall_mem_model: got=%h exp=%h", got, e); end
    checks++;
    if ({wb_wreg, wb_dest_addr, wb_dest_data} !== '0) begin
      failures++; $display("FAIL stall_mem_bubble: wreg=%b addr=%0d data=%h exp 0", wb_wreg, wb_dest_addr, wb_dest_data);
    end
    drive(1, 5'd10, 32'hCAFE_0002, 0, 32'h0, 32'h0);
    ctrl(0, 0, 0, 0);
    tick();
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(11 + i), 32'hBAD0_0000 + i, 1, 32'hBAD1_0000, 32'hBAD2_0000);
      ctrl(0, 0, i[0], 1);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL stall_wb_model: got=%h exp=%h", got, e); end
      checks++;
      if ({wb_wreg, wb_dest_addr, wb_dest_data, wb_whilo} !== {1'b1, 5'd10, 32'hCAFE_0002, 1'b0}) begin
        failures++; $display("FAIL stall_wb_hold: addr=%0d data=%h whilo=%b exp 10/cafe0002/0", wb_dest_addr, wb_dest_data, wb_whilo);
      end
    end
    ctrl(0, 0, 0, 0);
  endtask

  task automatic test_flush();
    drive(0, 5'd0, 32'h0, 1, 32'hAAAA_0000, 32'h0000_AAAA);
    tick();
    void'(exp_q.pop_front());
    drive(0, 5'd0, 32'h0, 1, 32'hBBBB_0000, 32'h0000_BBBB);
    ctrl(0, 1, 0, 0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL flush_model: got=%h exp=%h", got, e); end
    checks++;
    if ({wb_whilo, hi_rdata} !== {1'b0, 32'hAAAA_0000}) begin
      failures++; $display("FAIL flush_commit: whilo=%b hi=%h exp 0/aaaa0000", wb_whilo, hi_rdata);
    end
    drive(0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
    ctrl(0, 0, 0, 0);
    tick();
    void'(exp_q.pop_front());
    checks++;
    if (hi_rdata !== 32'hAAAA_0000) begin
      failures++; $display("FAIL flush_no_commit: hi=%h exp aaaa0000", hi_rdata);
    end
  endtask

  task automatic test_reg_zero();
    drive(1, 5'd0, 32'hFFFF_FFFF, 0, 32'h0, 32'h0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL reg_zero_model: got=%h exp=%h", got, e); end
    checks++;
    if ({wb_wreg, wb_dest_addr, wb_dest_data} !== {1'b0, 5'd0, 32'hFFFF_FFFF}) begin
      failures++; $display("FAIL reg_zero: wreg=%b addr=%0d data=%h exp 0/0/ffffffff", wb_wreg, wb_dest_addr, wb_dest_data);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 5'd0, 32'h0, 1, 32'h5555_5555, 32'h6666_6666);
    tick();
    void'(exp_q.pop_front());
    ctrl(1, 0, 0, 0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL reset_mid_model: got=%h exp=%h", got, e); end
    checks++;
    if ({hi_rdata, lo_rdata} !== '0) begin
      failures++; $display("FAIL reset_mid: hi=%h lo=%h exp 0", hi_rdata, lo_rdata);
    end
    ctrl(0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
            $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom);
      ctrl($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL random_%0d: got=%h exp=%h", i, got, e); end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
    mem_dest_addr = '0; mem_wreg = 1'b0; mem_dest_data = '0;
    mem_hi = '0; mem_lo = '0; mem_whilo = 1'b0;
    m_addr = '0; m_wreg = 1'b0; m_data = '0; m_hi = '0; m_lo = '0;
    m_whilo = 1'b0; m_hreg = '0; m_lreg = '0;
    test_reset();
    test_hilo_bypass();
    test_stall();
    test_flush();
    test_reg_zero();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
